keccak_theta_sched: RTL
=======================

Name: keccak_theta_sched

Overview:
- Sequences the shared 5-input 32-bit XOR parity unit through the Keccak theta step for one 1600-bit state.
- Phase 1: issues 10 column-half parity requests (5 columns × lo/hi 32-bit halves) and collects C[x] into a local register file.
- Phase 2: streams D[x] = C[(x+4)%5] ^ ROL64(C[(x+1)%5], ROT) for x = 0..4 to the theta apply stage over a valid/ready handshake.
- Sits between the SHA-3 round controller and the shared XOR datapath; the grant input lets other users share the XOR unit.

Parameters:
- HALF_W, 32, width of one lane half and of the XOR unit; the lane is 2*HALF_W.
- ROT, 1, left-rotate amount applied to C[(x+1)%5] in D. Legal range 0..2*HALF_W-1.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  synchronous active-high reset.
- i_start  input  1  one-cycle pulse; begins a theta pass when idle.
- o_busy  output  1  high from the cycle after an accepted start until o_done.
- o_done  output  1  one-cycle pulse after the last D word is accepted.
- o_par_req  output  1  request for the shared XOR unit.
- i_par_gnt  input  1  grant; a request is consumed in a cycle where o_par_req and i_par_gnt are both high.
- o_par_col  output  3  column x (0..4) of the current request.
- o_par_half  output  1  0 = lo half [HALF_W-1:0], 1 = hi half.
- i_parity  input  HALF_W  XOR unit result, valid exactly 1 cycle after the granted cycle.
- o_d_valid  output  1  D word valid.
- i_d_ready  input  1  downstream ready.
- o_d_x  output  3  column index of D.
- o_d_data  output  2*HALF_W  D[x] = {hi,lo}.

Behaviour:
- Reset: state IDLE; o_busy, o_done, o_par_req, o_d_valid = 0; o_par_col, o_par_half, o_d_x, o_d_data = 0; C file cleared; counters = 0. Reset mid-pass aborts the pass immediately. No partial D is emitted afterwards.
- IDLE: i_start=1 -> PAR with k=0. Otherwise stay. In any other state, i_start is ignored.
- PAR:
  - o_par_req=1, o_par_col=k>>1, o_par_half=k[0], for k = 0..9 (order: x0 lo, x0 hi, x1 lo, ..., x4 hi).
  - Request fields stay stable until granted.
  - On grant: record the tag (k) in a 1-deep pipeline register and increment k.
  - The cycle after each grant, write i_parity into C[tag].
  - A grant on k=9 -> WAIT. o_par_req drops in the same clock edge.
  - Back-to-back grants give 1 request per cycle; gaps in the grant only stall.
- WAIT: 1 cycle to capture the last parity -> DOUT with x=0.
- DOUT:
  - o_d_valid=1, o_d_x=x, o_d_data computed combinationally from the C file.
  - ROL64 operates on {C[hi],C[lo]}.
  - Data and index stay stable while valid && !ready.
  - On valid && ready: x increments. If x was 4 -> DONE.
- DONE: o_done=1 for 1 cycle, o_busy=0 in this cycle -> IDLE.
- o_busy=1 in PAR, WAIT and DOUT.
- Minimum pass latency with constant grant and ready: start accepted at cycle 0; 10 grant cycles; 1 WAIT cycle; 5 D cycles; o_done in cycle 17.
- The C file keeps its last values after done until the next pass overwrites them.
- A start in the same cycle as o_done is ignored (not IDLE yet).

Optional Feature:
- Macro: KECCAK_THETA_SCHED_ERR_EN.
- With the macro defined:
  - Adds output o_err (1 bit, reset 0) and input i_err_clr (1 bit).
  - o_err sets sticky when i_start=1 while not IDLE.
  - o_err clears on i_err_clr=1. Set takes priority over a simultaneous clear.
- Without the macro: the ports are absent and an ignored start has no observable effect.

Test Plan:
- All parities 0x00000000, grant and ready tied high -> five D words, x=0..4, each 0x0000000000000000. o_done at cycle 17 after start. o_busy falls in the same cycle.
- Parity 0x00000001 only for (x0, lo), others 0, ROT=1 -> D[1]=0x0000000000000001 and D[4]=0x0000000000000002; D[0], D[2], D[3]=0.
- Parity 0x80000000 only for (x2, hi), ROT=1:
  - D[1]=0x0000000000000001 (the rotate wraps the hi MSB into lo bit0).
  - D[3]=0x8000000000000000.
  - Others 0.
- Grant low for 3 cycles at k=4, and i_d_ready low for 2 cycles on x=2 -> o_par_col=2, o_par_half=0 held throughout the stall. o_d_x=2 and its data held stable. Results identical to the no-stall case.
- i_rst asserted during PAR at k=6 -> next cycle all outputs are 0 and the state is IDLE. A new start runs a full correct pass.
- With KECCAK_THETA_SCHED_ERR_EN: i_start during DOUT -> o_err=1 next cycle; the pass completes unaffected. i_err_clr -> o_err=0.

Source files
------------

// File: rtl/keccak_theta_sched.sv
// keccak_theta_sched
// ------------------
// Drives the shared 5-input XOR parity unit through the Keccak theta step
// for one 1600-bit state. It runs in two phases:
//   1. It requests 10 column-half parities (x0 lo, x0 hi, ... x4 hi) and
//      collects the column parities C[x] in a local register file.
//   2. It streams D[x] = C[(x+4)%5] ^ ROL(C[(x+1)%5], ROT) for x = 0..4 over
//      a valid/ready handshake.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_start                 one-cycle pulse that starts a pass when idle
//   o_busy / o_done         pass in progress / one-cycle completion pulse
//   o_par_req, i_par_gnt    request to, and grant from, the shared XOR unit
//   o_par_col, o_par_half   column and half of the current request
//   i_parity                XOR result, valid one cycle after the grant
//   o_d_valid, i_d_ready    handshake for the D stream
//   o_d_x, o_d_data         column index and 2*HALF_W-bit D word
//   o_err, i_err_clr        only present when KECCAK_THETA_SCHED_ERR_EN is
//                           defined: a sticky flag for a start that arrives
//                           while not idle, and its clear input
//
// Optional feature macro: KECCAK_THETA_SCHED_ERR_EN
module keccak_theta_sched #(
  parameter int HALF_W = 32,
  parameter int ROT    = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
`ifdef KECCAK_THETA_SCHED_ERR_EN
  output logic                  o_err,
  input  logic                  i_err_clr,
`endif
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_par_req,
  input  logic                  i_par_gnt,
  output logic [2:0]            o_par_col,
  output logic                  o_par_half,
  input  logic [HALF_W-1:0]     i_parity,
  output logic                  o_d_valid,
  input  logic                  i_d_ready,
  output logic [2:0]            o_d_x,
  output logic [2*HALF_W-1:0]   o_d_data
);

  localparam int LANE_W = 2 * HALF_W;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PAR  = 3'd1,
    S_WAIT = 3'd2,
    S_DOUT = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e              state_q;
  logic [3:0]          k_q;
  logic                busy_q;
  logic                done_q;
  logic                par_req_q;
  logic [2:0]          par_col_q;
  logic                par_half_q;
  logic                d_valid_q;
  logic [2:0]          d_x_q;
  logic                pend_q;
  logic [3:0]          tag_q;
  logic [HALF_W-1:0]   c_q [10];

  logic                gnt_s;
  logic [3:0]          k_nxt_s;
  logic [2:0]          idx_a_s;
  logic [2:0]          idx_b_s;
  logic [LANE_W-1:0]   lane_a_s;
  logic [LANE_W-1:0]   lane_b_s;
  logic [2*LANE_W-1:0] dbl_s;
  logic [LANE_W-1:0]   d_s;

  assign gnt_s   = par_req_q & i_par_gnt;
  assign k_nxt_s = k_q + 4'd1;

  // Sequencer FSM: the state, counters and all registered control outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      k_q        <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      par_req_q  <= 1'b0;
      par_col_q  <= 3'd0;
      par_half_q <= 1'b0;
      d_valid_q  <= 1'b0;
      d_x_q      <= 3'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_q    <= S_PAR;
            busy_q     <= 1'b1;
            par_req_q  <= 1'b1;
            k_q        <= 4'd0;
            par_col_q  <= 3'd0;
            par_half_q <= 1'b0;
          end
        end
        S_PAR: begin
          if (gnt_s) begin
            if (k_q == 4'd9) begin
              state_q    <= S_WAIT;
              par_req_q  <= 1'b0;
              par_col_q  <= 3'd0;
              par_half_q <= 1'b0;
              k_q        <= 4'd0;
            end else begin
              k_q        <= k_nxt_s;
              par_col_q  <= k_nxt_s[3:1];
              par_half_q <= k_nxt_s[0];
            end
          end
        end
        // The last parity is written to the C file at the end of this cycle.
        S_WAIT: begin
          state_q   <= S_DOUT;
          d_valid_q <= 1'b1;
          d_x_q     <= 3'd0;
        end
        S_DOUT: begin
          if (i_d_ready) begin
            if (d_x_q == 3'd4) begin
              state_q   <= S_DONE;
              d_valid_q <= 1'b0;
              d_x_q     <= 3'd0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              d_x_q <= d_x_q + 3'd1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Parity return path: the grant tag is held for one cycle, then i_parity is written to C[tag].
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend_q <= 1'b0;
      tag_q  <= 4'd0;
      for (int i = 0; i < 10; i++) begin
        c_q[i] <= {HALF_W{1'b0}};
      end
    end else begin
      pend_q <= gnt_s;
      tag_q  <= k_q;
      if (pend_q) begin
        c_q[tag_q] <= i_parity;
      end
    end
  end

  // Column selection for D[x]: a = (x+4)%5, b = (x+1)%5.
  always_comb begin
    idx_a_s = 3'd0;
    idx_b_s = 3'd0;
    case (d_x_q)
      3'd0:    begin idx_a_s = 3'd4; idx_b_s = 3'd1; end
      3'd1:    begin idx_a_s = 3'd0; idx_b_s = 3'd2; end
      3'd2:    begin idx_a_s = 3'd1; idx_b_s = 3'd3; end
      3'd3:    begin idx_a_s = 3'd2; idx_b_s = 3'd4; end
      3'd4:    begin idx_a_s = 3'd3; idx_b_s = 3'd0; end
      default: begin idx_a_s = 3'd0; idx_b_s = 3'd0; end
    endcase
  end

  // D word: lanes are {hi,lo}, and the rotate takes the upper half of the doubled lane shifted left.
  always_comb begin
    lane_a_s = {c_q[{idx_a_s, 1'b1}], c_q[{idx_a_s, 1'b0}]};
    lane_b_s = {c_q[{idx_b_s, 1'b1}], c_q[{idx_b_s, 1'b0}]};
    dbl_s    = {lane_b_s, lane_b_s} << ROT;
    d_s      = lane_a_s ^ dbl_s[2*LANE_W-1:LANE_W];
  end

`ifdef KECCAK_THETA_SCHED_ERR_EN
  logic err_q;

  // Sticky flag for a start that arrives outside IDLE; setting it wins over a clear.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      err_q <= 1'b0;
    end else if (i_start && (state_q != S_IDLE)) begin
      err_q <= 1'b1;
    end else if (i_err_clr) begin
      err_q <= 1'b0;
    end
  end

  assign o_err = err_q;
`endif

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_par_req  = par_req_q;
  assign o_par_col  = par_col_q;
  assign o_par_half = par_half_q;
  assign o_d_valid  = d_valid_q;
  assign o_d_x      = d_x_q;
  // Zero outside DOUT so that old C contents never show on the port.
  assign o_d_data   = d_valid_q ? d_s : {LANE_W{1'b0}};

endmodule
